// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Round-robin shared registered adder. N_REQ requesters each offer two
//   operands; one winner is accepted per transaction. The FSM runs
//   IDLE -> EXEC -> RESP. The sum and carry come back with the winner's ID on
//   a single response channel that supports backpressure.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready is a one-hot grant)
//   req_a, req_b          packed operands, requester i at [i*DATA_W +: DATA_W]
//   resp_valid/resp_ready response handshake
//   resp_id/sum/carry     response payload, held after resp_valid drops
//   busy                  FSM not idle
//   txn_count             completed responses, wrapping
module adder_share_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_a,
    input  logic [N_REQ*DATA_W-1:0]  req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [DATA_W-1:0]        resp_sum,
    output logic                     resp_carry,
    output logic                     busy,
    output logic [CNT_W-1:0]         txn_count
);

    localparam logic [ID_W:0]   NReqW  = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LastId = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]     resp_id_q, resp_id_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                carry_q, carry_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Round-robin search: rotate the request vector so that ptr lands at bit 0,
    // take the lowest set bit, then map the offset back into requester space.
    logic [2*N_REQ-1:0]  dbl;
    logic [N_REQ-1:0]    rot;
    logic [ID_W-1:0]     off;
    logic [ID_W:0]       win_ext;
    logic [ID_W-1:0]     win_id;
    logic                win_found;

    always_comb begin
        dbl       = {req_valid, req_valid} >> ptr_q;
        rot       = dbl[N_REQ-1:0];
        win_found = |rot;
        off       = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = ID_W'(k);
            end
        end
        win_ext = {1'b0, ptr_q} + {1'b0, off};
        if (win_ext >= NReqW) begin
            win_ext = win_ext - NReqW;
        end
        win_id = win_ext[ID_W-1:0];
    end

    logic [DATA_W-1:0] a_sel, b_sel;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_id == ID_W'(i)) begin
                a_sel = req_a[i*DATA_W +: DATA_W];
                b_sel = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        req_ready    = '0;

        case (state_q)
            StIdle: begin
                if (win_found) begin
                    req_ready = N_REQ'(1) << win_id;
                    a_d       = a_sel;
                    b_d       = b_sel;
                    id_d      = win_id;
                    ptr_d     = (win_id == LastId) ? '0 : win_id + 1'b1;
                    state_d   = StExec;
                end
            end
            StExec: begin
                {carry_d, sum_d} = {1'b0, a_q} + {1'b0, b_q};
                resp_id_d        = id_q;
                resp_valid_d     = 1'b1;
                state_d          = StResp;
            end
            StResp: begin
                // resp_valid is always set in this state, so ready alone completes.
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    cnt_d        = cnt_q + 1'b1;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!rst_n) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            cnt_q        <= cnt_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_sum   = sum_q;
    assign resp_carry = carry_q;
    assign busy       = (state_q != StIdle);
    assign txn_count  = cnt_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter. A transaction-level model
// predicts grants and phase timing and pushes the expected responses into a
// scoreboard. A separate monitor checks each response the DUT presents.
module tb_adder_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_a, req_b;
    logic [N-1:0]      req_ready;
    logic              resp_valid, resp_ready;
    logic [IW-1:0]     resp_id;
    logic [W-1:0]      resp_sum;
    logic              resp_carry, busy;
    logic [CW-1:0]     txn_count;

    always #5 clk = ~clk;

    adder_share_arbiter #(
        .N_REQ (N),
        .DATA_W(W),
        .ID_W  (IW),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_sum  (resp_sum),
        .resp_carry(resp_carry),
        .busy      (busy),
        .txn_count (txn_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [IW-1:0] id;
        logic [W-1:0]  sum;
        logic          carry;
    } exp_t;

    exp_t sb[$];

    // Transaction-level model: which phase of a transaction is in flight.
    typedef enum {MIdle, MExec, MResp} mphase_t;
    mphase_t        mph    = MIdle;
    int             mptr   = 0;
    logic [CW-1:0]  mcnt   = '0;
    bit             was_low = 1'b0;
    int             m_w;
    logic [W:0]     m_s;
    exp_t           m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("ready_in_reset", 64'(req_ready), 64'd0);
            if (was_low) begin
                chk("rst_resp_valid", 64'(resp_valid), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_txn_count", 64'(txn_count), 64'd0);
                chk("rst_resp_sum", 64'(resp_sum), 64'd0);
            end
            mph  = MIdle;
            mptr = 0;
            mcnt = '0;
            sb.delete();
            was_low = 1'b1;
        end else begin
            was_low = 1'b0;
            chk("txn_count", 64'(txn_count), 64'(mcnt));
            case (mph)
                MIdle: begin
                    chk("idle_resp_valid", 64'(resp_valid), 64'd0);
                    chk("idle_busy", 64'(busy), 64'd0);
                    m_w = -1;
                    for (int k = 0; k < N; k++) begin
                        if (m_w < 0 && req_valid[(mptr + k) % N]) m_w = (mptr + k) % N;
                    end
                    if (m_w < 0) begin
                        chk("no_grant", 64'(req_ready), 64'd0);
                    end else begin
                        chk("grant", 64'(req_ready), 64'd1 << m_w);
                        m_s = {1'b0, req_a[m_w*W +: W]} + {1'b0, req_b[m_w*W +: W]};
                        m_e.id    = IW'(m_w);
                        m_e.sum   = m_s[W-1:0];
                        m_e.carry = m_s[W];
                        sb.push_back(m_e);
                        mptr = (m_w + 1) % N;
                        mph  = MExec;
                    end
                end
                MExec: begin
                    chk("exec_busy", 64'(busy), 64'd1);
                    chk("exec_resp_valid", 64'(resp_valid), 64'd0);
                    chk("exec_ready", 64'(req_ready), 64'd0);
                    mph = MResp;
                end
                MResp: begin
                    chk("resp_busy", 64'(busy), 64'd1);
                    chk("resp_valid", 64'(resp_valid), 64'd1);
                    chk("resp_ready_out", 64'(req_ready), 64'd0);
                    if (resp_ready) begin
                        mcnt = mcnt + 1'b1;
                        mph  = MIdle;
                    end
                end
                default: mph = MIdle;
            endcase
        end
    end

    // Monitor: compares every presented response with the scoreboard head and
    // retires it on handshake.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got id=%0d sum=%0h expected no response",
                         resp_id, resp_sum);
            end else begin
                chk("resp_id", 64'(resp_id), 64'(sb[0].id));
                chk("resp_sum", 64'(resp_sum), 64'(sb[0].sum));
                chk("resp_carry", 64'(resp_carry), 64'(sb[0].carry));
                if (resp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_op();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) return 32'hFFFF_FFFF;
        if (r == 1) return 32'h0;
        return W'($urandom);
    endfunction

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // Raise mask, wait (bounded) for a grant to any bit in it, then drop all.
    task automatic req_mask(input logic [N-1:0] mask);
        bit ok;
        ok = 1'b0;
        req_valid = mask;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if ((req_ready & mask) != '0) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL grant_timeout: got no grant expected grant for mask %b", mask);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    logic [N-1:0] g;

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        do_reset();
        resp_ready = 1'b1;

        // Simple add from requester 0.
        set_ops(0, 32'd10, 32'd20);
        req_mask(4'b0001);
        wait_idle();

        // Overflow with carry.
        set_ops(1, 32'hFFFF_FFFF, 32'h0000_0002);
        req_mask(4'b0010);
        wait_idle();

        // Fairness from a fresh pointer: all requesters continuously valid.
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, rnd_op(), rnd_op());
        req_valid = '1;
        repeat (18) tick();
        req_valid = '0;
        wait_idle();

        // Backpressure: response held for several cycles.
        resp_ready = 1'b0;
        set_ops(3, 32'h1234_5678, 32'h1111_1111);
        req_mask(4'b1000);
        repeat (6) tick();
        resp_ready = 1'b1;
        wait_idle();

        // Pointer at 3 after serving requester 2, then wrapping searches.
        set_ops(2, 32'd7, 32'd8);
        req_mask(4'b0100);
        wait_idle();
        set_ops(2, 32'd100, 32'd200);
        req_mask(4'b0100);
        wait_idle();
        set_ops(0, 32'd5, 32'd6);
        req_valid = 4'b0101;
        tick();
        req_valid = '0;
        wait_idle();

        // Reset during EXEC discards the in-flight transaction.
        set_ops(1, 32'hDEAD_0000, 32'h0000_BEEF);
        req_mask(4'b0010);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        set_ops(0, 32'd1, 32'd2);
        req_mask(4'b0001);
        wait_idle();

        // Randomized traffic obeying the requester rules.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            g = req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !g[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_ops(i, rnd_op(), rnd_op());
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end

        req_valid  = '0;
        resp_ready = 1'b1;
        wait_idle();
        repeat (3) tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
